// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the 3x3 convolution core.
// Loads the 9-entry shadow kernel into the core at frame start, gates one IMG_W x IMG_H frame
// of source pixels into the core's valid-only input, then waits for the output stream to drain.
// Optional macro CONV_CTRL_PERF_EN adds the stall_count output (source-idle STREAM cycles).
module conv_frame_ctrl #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned IMG_W     = 128,
  parameter int unsigned IMG_H     = 128,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned DRAIN_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr,
  input  logic [3:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic                     src_valid,
  input  logic [PIX_W-1:0]         src_data,
  output logic                     src_ready,
  output logic                     conv_kernel_wr,
  output logic [3:0]               conv_kernel_addr,
  output logic signed [COEF_W-1:0] conv_kernel_data,
  output logic                     conv_valid_in,
  output logic [PIX_W-1:0]         conv_px_in,
  input  logic                     conv_valid_out,
  output logic [CNT_W-1:0]         out_count
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_count
`endif
);

  localparam logic [CNT_W-1:0] LastPix   = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {StIdle, StLoadK, StStream, StDrain, StDone} state_e;

  state_e                     r_state;
  logic signed [COEF_W-1:0]   r_shadow [9];
  logic [3:0]                 r_k;
  logic [CNT_W-1:0]           r_pix_cnt;
  logic [CNT_W-1:0]           r_drain_cnt;
  logic [CNT_W-1:0]           r_out_count;
  logic                       r_done;
  logic                       r_kwr;
  logic [3:0]                 r_kaddr;
  logic signed [COEF_W-1:0]   r_kdata;
  logic                       r_valid_in;
  logic [PIX_W-1:0]           r_px;

  logic                       w_start_ok;
  logic                       w_accept;
  logic                       w_counting;
  logic [3:0]                 w_k_idx;
  logic [3:0]                 w_k_sel;
  logic signed [COEF_W-1:0]   w_k_data;

  assign busy       = (r_state != StIdle);
  assign src_ready  = (r_state == StStream) && !abort;
  assign w_accept   = src_valid && src_ready;
  assign w_start_ok = (r_state == StIdle) && start && !abort;
  assign w_counting = (r_state == StStream) || (r_state == StDrain);

  // Index 0 is issued on the start edge itself, so the 9 writes coincide with the LOAD_K state.
  assign w_k_idx  = (r_state == StIdle) ? 4'd0 : r_k;
  assign w_k_sel  = (w_k_idx > 4'd8) ? 4'd0 : w_k_idx;
  // Forward a same-cycle CPU write so it reaches the core if its index is not yet sent.
  assign w_k_data = (cfg_wr && (cfg_addr == w_k_sel)) ? cfg_data : r_shadow[w_k_sel];

  assign done             = r_done;
  assign conv_kernel_wr   = r_kwr;
  assign conv_kernel_addr = r_kaddr;
  assign conv_kernel_data = r_kdata;
  assign conv_valid_in    = r_valid_in;
  assign conv_px_in       = r_px;
  assign out_count        = r_out_count;

  // Shadow kernel: CPU writes to indices 0..8 in any state; higher indices are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_shadow[i] <= '0;
    end else if (cfg_wr && (cfg_addr <= 4'd8)) begin
      r_shadow[cfg_addr] <= cfg_data;
    end
  end

  // Frame sequencer with registered kernel, pixel and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_pix_cnt   <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_kwr       <= 1'b0;
      r_kaddr     <= '0;
      r_kdata     <= '0;
      r_valid_in  <= 1'b0;
      r_px        <= '0;
    end else begin
      r_done     <= 1'b0;
      r_kwr      <= 1'b0;
      r_valid_in <= 1'b0;
      if (abort && (r_state != StIdle)) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start_ok) begin
              r_state     <= StLoadK;
              r_pix_cnt   <= '0;
              r_drain_cnt <= '0;
              r_kwr       <= 1'b1;
              r_kaddr     <= 4'd0;
              r_kdata     <= w_k_data;
              r_k         <= 4'd1;
            end
          end
          StLoadK: begin
            if (r_k == 4'd9) begin
              r_state <= StStream;
            end else begin
              r_kwr   <= 1'b1;
              r_kaddr <= r_k;
              r_kdata <= w_k_data;
              r_k     <= r_k + 4'd1;
            end
          end
          StStream: begin
            if (w_accept) begin
              r_valid_in <= 1'b1;
              r_px       <= src_data;
              r_pix_cnt  <= r_pix_cnt + CNT_W'(1);
              if (r_pix_cnt == LastPix) r_state <= StDrain;
            end
          end
          StDrain: begin
            if (conv_valid_out) begin
              r_drain_cnt <= '0;
            end else if (r_drain_cnt == DrainLast) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + CNT_W'(1);
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Core output counter: cleared by an accepted start, saturating, frozen outside STREAM/DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_count <= '0;
    end else if (w_start_ok) begin
      r_out_count <= '0;
    end else if (w_counting && conv_valid_out && !abort && !(&r_out_count)) begin
      r_out_count <= r_out_count + CNT_W'(1);
    end
  end

`ifdef CONV_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  assign stall_count = r_stall_cnt;

  // Source-idle STREAM cycles for the current or last frame, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == StStream) && !src_valid && !abort && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame-level sequencer for the 3x3 convolution datapath.
- Holds a CPU-writable shadow copy of the 9 kernel coefficients and pushes them into the convolution core's kernel write port at frame start.
- Gates one IMG_W x IMG_H frame of pixels from a ready/valid source into the core's valid-only stream, then counts core outputs until the pipeline drains.
- Sits between the CSR/DMA side and the convolution core. The core has no backpressure, so this block is the only flow-control point.

Parameters:
- PIX_W, 8, pixel width.
- COEF_W, 16, signed kernel coefficient width.
- IMG_W, 128, pixels per line.
- IMG_H, 128, lines per frame.
- CNT_W, 24, width of the pixel and output counters; must satisfy 2^CNT_W > IMG_W*IMG_H.
- DRAIN_CYC, 16, number of consecutive output-idle cycles after the last input that ends a frame; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- cfg_wr  in  1  shadow coefficient write strobe.
- cfg_addr  in  4  coefficient index 0..8; writes to 9..15 are ignored.
- cfg_data  in  COEF_W  signed coefficient value.
- start  in  1  start-frame pulse.
- abort  in  1  abort the current frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal frame completion.
- src_valid  in  1  source pixel valid.
- src_data  in  PIX_W  source pixel.
- src_ready  out  1  source accept.
- conv_kernel_wr  out  1  core kernel write strobe.
- conv_kernel_addr  out  4  core kernel index.
- conv_kernel_data  out  COEF_W  core kernel coefficient.
- conv_valid_in  out  1  core pixel valid.
- conv_px_in  out  PIX_W  core pixel.
- conv_valid_out  in  1  core output-valid, observed only (not consumed).
- out_count  out  CNT_W  number of core outputs seen in the current or last frame.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; shadow kernel = 0.
  - busy, done, src_ready, conv_kernel_wr, conv_valid_in = 0.
  - conv_kernel_addr, conv_kernel_data, conv_px_in, out_count, all counters = 0.
- Shadow writes:
  - cfg_wr with cfg_addr <= 8 writes cfg_data into shadow[cfg_addr] on the next edge, in any state.
  - A write during LOAD_K to an index not yet transferred is sent in the current frame. Otherwise it takes effect on the next frame.
- FSM states: IDLE -> LOAD_K -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 and abort=0 -> LOAD_K.
  - On that edge: out_count, pixel counter, k index and drain counter are cleared.
  - start while busy is ignored.
- LOAD_K, 9 cycles:
  - Registered outputs: conv_kernel_wr=1, conv_kernel_addr=k, conv_kernel_data=shadow[k], for k=0..8 on consecutive cycles.
  - After k=8 is issued -> STREAM. conv_kernel_wr is 0 in every other state.
- STREAM:
  - src_ready = 1, decoded combinationally from state.
  - On an accepted beat (src_valid & src_ready), next edge: conv_valid_in=1, conv_px_in=src_data. Otherwise conv_valid_in=0 and conv_px_in holds. Latency from source to core is 1 cycle.
  - The pixel counter increments per accept. An accept with counter = IMG_W*IMG_H-1 -> DRAIN, so src_ready is 0 in the following cycle.
  - Source stalls (src_valid=0) are allowed indefinitely.
- DRAIN:
  - src_ready = 0.
  - The drain counter increments each cycle and is cleared on conv_valid_out=1.
  - Drain counter reaching DRAIN_CYC-1 with conv_valid_out=0 -> DONE.
- DONE:
  - done = 1 for exactly this one cycle, then -> IDLE.
- out_count:
  - Increments on every cycle with conv_valid_out=1 while in STREAM or DRAIN; saturates at all-ones.
  - Held in IDLE until the next accepted start.
- busy = (state != IDLE), decoded combinationally.
- abort=1 in any non-IDLE state:
  - -> IDLE next edge; done not pulsed; conv_valid_in and conv_kernel_wr are 0 from that edge; out_count holds its value.
  - abort and start together in IDLE: abort wins, stay IDLE.
- A pixel presented on the abort cycle is not accepted: src_ready is 0 whenever abort=1.

Optional Feature:
- Macro CONV_CTRL_PERF_EN.
- Defined: adds output stall_count [CNT_W]. It counts STREAM cycles with src_valid=0, is cleared on an accepted start, saturates at all-ones, and holds in IDLE. Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Kernel load: write shadow[0..8] = -1,0,1,-2,0,2,-1,0,1, then start -> 9 consecutive conv_kernel_wr cycles, addr 0..8, data matching; busy=1 from the cycle after start.
- Full frame, IMG_W=4, IMG_H=4, src_valid always 1 -> exactly 16 conv_valid_in pulses, each 1 cycle after its accept; src_ready falls after the 16th accept.
- Drain/done: model returns 4 conv_valid_out pulses during STREAM/DRAIN -> out_count=4; done pulses once, exactly DRAIN_CYC cycles after the last output; busy=0 the next cycle.
- Source stalls: src_valid toggles 1,0,0,1,... -> still exactly 16 core pixels, in order with matching data. With CONV_CTRL_PERF_EN, stall_count equals the number of idle STREAM cycles.
- Abort mid-STREAM after 7 accepts -> IDLE next edge, no done pulse, src_ready=0; a following start runs a full 16-pixel frame.
- Edge cases:
  - start while busy is ignored.
  - cfg_addr=12 write leaves shadow unchanged.
  - rst asserted mid-LOAD_K clears all outputs immediately, without waiting for a clock edge.
